muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port: clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: Start  in  1  single-cycle request; operands and Op are sampled on the same edge.
REQ-004 SHALL have port: Op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port: Operand_A  in  32  multiplicand / dividend (Read_data_1).
REQ-006 SHALL have port: Operand_B  in  32  multiplier / divisor (Read_data_2).
REQ-007 SHALL have port: Cancel  in  1  pipeline flush; aborts an in-flight operation.
REQ-008 SHALL have port: Hi_we, Lo_we  in  1 each  MTHI/MTLO write strobes.
REQ-009 SHALL have port: Wr_data  in  32  MTHI/MTLO data.
REQ-010 SHALL have port: Busy  out  1  operation in flight; the pipeline stalls on MFHI/MFLO/new Start while high.
REQ-011 SHALL have port: Done  out  1  one-cycle pulse; HI/LO hold the new result in that cycle.
REQ-012 SHALL have port: Div_zero  out  1  sticky flag; set by DIV/DIVU with B=0, cleared by the next accepted Start.
REQ-013 SHALL have ports: HI, LO  out  32 each  architectural HI/LO registers.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-015 IDLE: SHALL accept Start when Busy=0; a Start while Busy=1 SHALL be ignored without corrupting state.
REQ-016 On accept, SHALL register |A| and |B| for signed ops (raw values for unsigned ops), store the result-sign bits, load count=31, and go to RUN.
REQ-017 RUN: SHALL perform one shift-add (multiply) or one restoring-subtract (divide) step per cycle, decrement count, and go to FIX after the step with count=0 (32 RUN cycles).
REQ-018 FIX: SHALL negate the 64-bit product if signs differ (MULT only); for DIV, SHALL negate the quotient if signs differ and give the remainder the dividend's sign.
REQ-019 FIX: SHALL write HI=product[63:32] / remainder and LO=product[31:0] / quotient, then go to DONE.
REQ-020 DONE: SHALL assert Done for one cycle and return to IDLE.
REQ-021 Latency: with Start sampled at edge k, Done SHALL be high in the cycle following edge k+34, and Busy SHALL be high from edge k+1 until Done.
REQ-022 Divide by zero: SHALL skip RUN, set Div_zero, set HI=A and LO=32'hFFFFFFFF, and pulse Done at edge k+2.
REQ-023 MULT/MULTU SHALL produce the exact 64-bit result for all inputs, including 0x80000000 * 0x80000000.
REQ-024 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0 (wrap, no trap).
REQ-025 Cancel: SHALL force IDLE on the next edge, deassert Busy, suppress Done, and leave HI/LO unchanged from before the aborted op.
REQ-026 Start and Cancel in the same cycle: Cancel SHALL win and Start SHALL be dropped.
REQ-027 Hi_we/Lo_we SHALL update HI/LO only in IDLE and SHALL be ignored while Busy.
REQ-028 In the DONE cycle, Hi_we/Lo_we SHALL be ignored; Done is the last writer.
REQ-029 HI/LO SHALL never change except in FIX, on an accepted Hi_we/Lo_we, or on reset.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE and clear Busy, Done, Div_zero, HI, LO, count, and internal accumulators to 0, including mid-operation.
REQ-031 The first Start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-032 Op encodings, FSM state codes, and the constant RUN_CYCLES=32 SHALL live in definitions.v beside the existing EXE_* constants.
REQ-033 The per-step shift/add/subtract datapath SHALL be one sub-module, muldiv_step (combinational, 64-bit accumulator in and out).
REQ-034 The FSM, counter, sign fix-up, and HI/LO registers SHALL stay in muldiv_seq.

Verification
REQ-035 MULT A=0xFFFFFFFE(-2), B=3 -> Done at k+34, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-036 DIVU A=100, B=7 -> HI=2, LO=14; DIV A=-7, B=2 -> HI=0xFFFFFFFF(-1), LO=0xFFFFFFFD(-3).
REQ-037 DIV A=5, B=0 -> Done at k+2, Div_zero=1, HI=5, LO=0xFFFFFFFF.
REQ-038 MULTU 0xFFFFFFFF*0xFFFFFFFF, with Cancel at k+10 -> Busy=0 at k+11, no Done pulse, HI/LO unchanged.
REQ-039 Second Start at k+5 during a MULT -> ignored; exactly one Done at k+34 with the first op's result.
REQ-040 rst_n pulsed low at k+20 mid-DIV -> all outputs 0 immediately; a new Start after release completes normally.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: operation
// encodings, FSM state codes, iteration count and small operand helpers.
package muldiv_seq_pkg;

  localparam int XLEN = 32;

  // Operation select as presented on the Op port.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  // One iteration per operand bit.
  localparam int RUN_CYCLES = 32;
  localparam int COUNT_W    = $clog2(RUN_CYCLES);
  localparam logic [COUNT_W-1:0] COUNT_LOAD = COUNT_W'(RUN_CYCLES - 1);

  // Bit 1 of the encoding selects divide, bit 0 selects unsigned.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude of -2^31.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath.
// Multiply: acc = {partial_product, multiplier}; add the multiplicand to the
// upper half when the multiplier LSB is set, then shift right one bit with the
// add carry entering at the top.
// Divide (restoring): acc = {remainder, dividend}; shift left one bit, try to
// subtract the divisor from the 33-bit shifted remainder, keep the difference
// and shift in a quotient 1 when it does not borrow.
module muldiv_step
  import muldiv_seq_pkg::*;
(
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   operand,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;

  // Compute both candidate steps and select by operation.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    sum     = '0;
    trial   = '0;
    acc_out = acc_in;
    if (is_div) begin
      trial = acc_in[2*XLEN-1:XLEN-1] - {1'b0, operand};
      if (!trial[XLEN]) begin
        acc_out = {trial[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
      end else begin
        acc_out = {acc_in[2*XLEN-2:0], 1'b0};
      end
    end else begin
      sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} +
                (acc_in[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
      acc_out = {sum, acc_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiply / 32/32 divide unit with architectural HI/LO.
// A started operation runs 32 single-bit iterations, a sign fix-up cycle that
// writes HI/LO, and a final cycle after which Done pulses for one cycle.
// Divide by zero bypasses the iterations. Cancel aborts without touching HI/LO.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic        clock,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] Operand_A,
  input  logic [31:0] Operand_B,
  input  logic        Cancel,
  input  logic        Hi_we,
  input  logic        Lo_we,
  input  logic [31:0] Wr_data,
  output logic        Busy,
  output logic        Done,
  output logic        Div_zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  state_e state, state_next;

  logic               accept;
  logic               fix_write;
  logic               done_set;
  logic               start_div;
  logic               start_signed;
  logic               start_div_zero;
  logic               start_neg;
  logic [XLEN-1:0]    mag_a, mag_b;

  logic [2*XLEN-1:0]  acc, acc_step;
  logic [XLEN-1:0]    operand;
  logic [COUNT_W-1:0] count;
  logic               op_div_q;
  logic               neg_res;
  logic               neg_rem;
  logic               done_q;
  logic               div_zero_q;
  logic [XLEN-1:0]    hi_q, lo_q;

  logic [2*XLEN-1:0]  prod_fix;
  logic [XLEN-1:0]    fix_hi, fix_lo;
  logic               mt_ok;

  // Decode of the request presented this cycle.
  assign start_div      = op_is_div(Op);
  assign start_signed   = op_is_signed(Op);
  assign start_div_zero = start_div && (Operand_B == '0);
  assign start_neg      = start_signed && (Operand_A[XLEN-1] ^ Operand_B[XLEN-1]);
  assign mag_a          = start_signed ? abs_val(Operand_A) : Operand_A;
  assign mag_b          = start_signed ? abs_val(Operand_B) : Operand_B;

  // MTHI/MTLO only land when idle and not in the cycle Done is shown.
  assign mt_ok = (state == IDLE) && !done_q;

  assign Busy     = (state != IDLE);
  assign Done     = done_q;
  assign Div_zero = div_zero_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

  muldiv_step u_step (
    .acc_in  (acc),
    .operand (operand),
    .is_div  (op_div_q),
    .acc_out (acc_step)
  );

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and per-cycle control strobes; Cancel overrides all.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    fix_write  = 1'b0;
    done_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          accept     = 1'b1;
          state_next = start_div_zero ? FIX : RUN;
        end
      end
      RUN: begin
        if (count == '0) state_next = FIX;
      end
      FIX: begin
        fix_write  = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done_set   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (Cancel) begin
      state_next = IDLE;
      accept     = 1'b0;
      fix_write  = 1'b0;
      done_set   = 1'b0;
    end
  end

  // Operand capture on accept, one datapath step per RUN cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      operand    <= '0;
      count      <= '0;
      op_div_q   <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (accept) begin
      op_div_q   <= start_div;
      count      <= COUNT_LOAD;
      div_zero_q <= start_div_zero;
      if (start_div_zero) begin
        // Preload so the divide fix-up yields HI=A, LO=all ones.
        acc     <= {Operand_A, {XLEN{1'b1}}};
        operand <= '0;
        neg_res <= 1'b0;
        neg_rem <= 1'b0;
      end else if (start_div) begin
        acc     <= {{XLEN{1'b0}}, mag_a};
        operand <= mag_b;
        neg_res <= start_neg;
        neg_rem <= start_signed && Operand_A[XLEN-1];
      end else begin
        acc     <= {{XLEN{1'b0}}, mag_b};
        operand <= mag_a;
        neg_res <= start_neg;
        neg_rem <= 1'b0;
      end
    end else if (state == RUN && !Cancel) begin
      acc <= acc_step;
      if (count != '0) count <= count - COUNT_W'(1);
    end
  end

  // Sign fix-up of the finished magnitudes.
  always_comb begin
    prod_fix = neg_res ? (~acc + 1'b1) : acc;
    fix_hi   = prod_fix[2*XLEN-1:XLEN];
    fix_lo   = prod_fix[XLEN-1:0];
    if (op_div_q) begin
      fix_lo = neg_res ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
      fix_hi = neg_rem ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    end
  end

  // Architectural HI/LO: written by the fix-up cycle or by MTHI/MTLO.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fix_write) begin
      hi_q <= fix_hi;
      lo_q <= fix_lo;
    end else if (mt_ok) begin
      if (Hi_we) hi_q <= Wr_data;
      if (Lo_we) lo_q <= Wr_data;
    end
  end

  // Done pulse, registered on leaving the DONE state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= done_set;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed operations push their expected
// HI/LO/Div_zero and Done edge; a monitor pops and compares on every Done.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        Start, Cancel, Hi_we, Lo_we;
  logic [1:0]  Op;
  logic [31:0] Operand_A, Operand_B, Wr_data;
  logic        Busy, Done, Div_zero;
  logic [31:0] HI, LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_seq dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .Start     (Start),
    .Op        (Op),
    .Operand_A (Operand_A),
    .Operand_B (Operand_B),
    .Cancel    (Cancel),
    .Hi_we     (Hi_we),
    .Lo_we     (Lo_we),
    .Wr_data   (Wr_data),
    .Busy      (Busy),
    .Done      (Done),
    .Div_zero  (Div_zero),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (rst_n && Done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi",       64'(HI),       64'(e.hi));
        check("lo",       64'(LO),       64'(e.lo));
        check("div_zero", 64'(Div_zero), 64'(e.dz));
        check("done_edge", 64'(edge_cnt), 64'(e.edge_no));
      end
    end
  end

  // Present a request for one cycle; k is the edge that samples it.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input logic [31:0] eh, input logic [31:0] el,
                       input logic edz, input int lat, output int k);
    @(negedge clock);
    Start = 1'b1; Op = op; Operand_A = a; Operand_B = b;
    k = edge_cnt + 1;
    if (push) sb.push_back(exp_t'{eh, el, edz, k + lat});
    @(negedge clock);
    Start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(negedge clock);
      #1;
    end
    check("drain_pending", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic wait_edge(input int target);
    while (edge_cnt < target) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [31:0] hi_save, lo_save;

    rst_n = 1'b0; Start = 0; Cancel = 0; Hi_we = 0; Lo_we = 0;
    Op = 2'b00; Operand_A = '0; Operand_B = '0; Wr_data = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_hi",   64'(HI),   64'd0);
    check("rst_lo",   64'(LO),   64'd0);
    rst_n = 1'b1;

    // MULT -2 * 3, with Busy tracking and MTHI/MTLO in the Done cycle.
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 34, k);
    check("busy_after_start", 64'(Busy), 64'd1);
    wait_edge(k + 33);
    check("busy_before_done", 64'(Busy), 64'd1);
    wait_edge(k + 34);
    Hi_we = 1'b1; Lo_we = 1'b1; Wr_data = 32'hDEAD_BEEF;
    @(negedge clock);
    Hi_we = 1'b0; Lo_we = 1'b0;
    check("done_cycle_mt_hi", 64'(HI), 64'hFFFF_FFFF);
    check("done_cycle_mt_lo", 64'(LO), 64'hFFFF_FFFA);
    wait_drain();

    issue(OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, 34, k);
    wait_drain();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34, k);
    wait_drain();

    // Divide by zero: short path, sticky flag.
    issue(OP_DIV, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1, 2, k);
    wait_drain();
    @(negedge clock);
    check("div_zero_sticky", 64'(Div_zero), 64'd1);

    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0000_0000, 0, 34, k);
    wait_drain();
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 0, 34, k);
    wait_drain();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h8000_0000, 0, 34, k);
    wait_drain();

    // MTHI / MTLO while idle.
    @(negedge clock);
    Hi_we = 1'b1; Wr_data = 32'h1234_5678;
    @(negedge clock);
    Hi_we = 1'b0; Lo_we = 1'b1; Wr_data = 32'h9ABC_DEF0;
    @(negedge clock);
    Lo_we = 1'b0;
    check("mthi", 64'(HI), 64'h1234_5678);
    check("mtlo", 64'(LO), 64'h9ABC_DEF0);

    // Cancel mid-MULTU: no Done, HI/LO untouched.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, '0, '0, 0, 34, k);
    wait_edge(k + 10);
    Cancel = 1'b1;
    @(negedge clock);
    Cancel = 1'b0;
    check("cancel_busy", 64'(Busy), 64'd0);
    repeat (40) @(negedge clock);
    check("cancel_hi", 64'(HI), 64'h1234_5678);
    check("cancel_lo", 64'(LO), 64'h9ABC_DEF0);

    // Start and Cancel together: Start dropped.
    @(negedge clock);
    Start = 1'b1; Cancel = 1'b1; Op = OP_MULT; Operand_A = 32'd3; Operand_B = 32'd3;
    @(negedge clock);
    Start = 1'b0; Cancel = 1'b0;
    check("start_cancel_busy", 64'(Busy), 64'd0);
    repeat (40) @(negedge clock);
    check("start_cancel_hi", 64'(HI), 64'h1234_5678);

    // Second Start and an MTHI while busy are both ignored.
    hi_save = HI;
    lo_save = LO;
    issue(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 34, k);
    wait_edge(k + 4);
    Start = 1'b1; Op = OP_DIVU; Operand_A = 32'd9; Operand_B = 32'd0;
    Hi_we = 1'b1; Lo_we = 1'b1; Wr_data = 32'h5555_5555;
    @(negedge clock);
    Start = 1'b0; Hi_we = 1'b0; Lo_we = 1'b0;
    check("busy_mthi_ignored", 64'(HI), 64'(hi_save));
    check("busy_mtlo_ignored", 64'(LO), 64'(lo_save));
    check("busy_start_no_dz",  64'(Div_zero), 64'd0);
    wait_drain();
    repeat (40) @(negedge clock);

    // Reset mid-DIV, then a Start on the first edge after release.
    issue(OP_DIVU, 32'd1000, 32'd3, 1, 32'd1, 32'd333, 0, 34, k);
    wait_edge(k + 20);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_busy", 64'(Busy), 64'd0);
    check("midrst_hi",   64'(HI),   64'd0);
    check("midrst_lo",   64'(LO),   64'd0);
    @(negedge clock);
    rst_n = 1'b1;
    Start = 1'b1; Op = OP_MULTU; Operand_A = 32'd6; Operand_B = 32'd7;
    k = edge_cnt + 1;
    sb.push_back(exp_t'{32'd0, 32'd42, 1'b0, k + 34});
    @(negedge clock);
    Start = 1'b0;
    check("post_rst_accept", 64'(Busy), 64'd1);
    wait_drain();

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
